ps2_scan_ctrl: RTL and testbench

Scan-code sequencer behind the PS/2 receive function module. It consumes the byte stream (`oTrig`/`oData`) from the receiver and resolves the E0/F0 prefixes and the E1 pause sequence into single key events. It tracks modifier state and buffers events in a small FIFO with a valid/ready handshake to the application logic.

---
 rtl/ps2_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0/E1 prefixes into key events, tracks modifiers, buffers events in a FIFO.
// Optional feature macro: PS2_PAUSE_EN builds the E1 pause-sequence state and its counter.
module ps2_scan_ctrl #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic       iTrig,
    input  logic [7:0] iData,
    output logic       oEvt_Valid,
    input  logic       iEvt_Ready,
    output logic [7:0] oEvt_Code,
    output logic       oEvt_Ext,
    output logic       oEvt_Break,
    output logic [3:0] oMod,
    output logic       oDrop,
    output logic [2:0] oState
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CYC - 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef PS2_PAUSE_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXT    = 3'd1,
        BRK    = 3'd2,
        EXTBRK = 3'd3,
        PAUSE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EXT    = 3'd1,
        BRK    = 3'd2,
        EXTBRK = 3'd3
    } state_t;
`endif

    state_t        state;
    state_t        nxtState;
    logic [TW-1:0] gapCnt;
    logic          timeout;
    logic          emit;
    logic          emitExt;
    logic          emitBrk;
    logic [7:0]    emitCode;
    logic          isCtrl;
    logic          isPrefix;
`ifdef PS2_PAUSE_EN
    logic [2:0]    pauseCnt;
    logic          pauseLoad;
`endif

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign isCtrl   = iData inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    assign isPrefix = iData inside {8'hE0, 8'hE1, 8'hF0};

    always_comb begin
        nxtState = state;
        emit     = 1'b0;
        emitExt  = 1'b0;
        emitBrk  = 1'b0;
        emitCode = iData;
        timeout  = 1'b0;
`ifdef PS2_PAUSE_EN
        pauseLoad = 1'b0;
`endif
        if (iTrig) begin
            case (state)
                IDLE: begin
                    if (iData == 8'hE0) begin
                        nxtState = EXT;
                    end else if (iData == 8'hF0) begin
                        nxtState = BRK;
`ifdef PS2_PAUSE_EN
                    end else if (iData == 8'hE1) begin
                        nxtState  = PAUSE;
                        pauseLoad = 1'b1;
`endif
                    end else if (!isCtrl && iData != 8'hE1) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (iData == 8'hF0) begin
                        nxtState = EXTBRK;
                    end else if (iData != 8'hE0) begin
                        emit     = 1'b1;
                        emitExt  = 1'b1;
                        nxtState = IDLE;
                    end
                end
                BRK: begin
                    nxtState = IDLE;
                    if (!isPrefix) begin
                        emit    = 1'b1;
                        emitBrk = 1'b1;
                    end
                end
                EXTBRK: begin
                    nxtState = IDLE;
                    if (!isPrefix) begin
                        emit    = 1'b1;
                        emitExt = 1'b1;
                        emitBrk = 1'b1;
                    end
                end
`ifdef PS2_PAUSE_EN
                PAUSE: begin
                    if (pauseCnt == 3'd1) begin
                        emit     = 1'b1;
                        emitExt  = 1'b1;
                        emitCode = 8'hE1;
                        nxtState = IDLE;
                    end
                end
`endif
                default: nxtState = IDLE;
            endcase
        end else if (state != IDLE && gapCnt == GAP_LAST) begin
            // a byte arriving on the expiry cycle takes the branch above instead
            timeout  = 1'b1;
            nxtState = IDLE;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            state  <= IDLE;
            gapCnt <= '0;
            oMod   <= '0;
            oDrop  <= 1'b0;
`ifdef PS2_PAUSE_EN
            pauseCnt <= '0;
`endif
        end else begin
            state  <= nxtState;
            oDrop  <= drop;
            if (iTrig || state == IDLE || timeout) begin
                gapCnt <= '0;
            end else begin
                gapCnt <= gapCnt + 1'b1;
            end
`ifdef PS2_PAUSE_EN
            if (pauseLoad) begin
                pauseCnt <= 3'd7;
            end else if (iTrig && state == PAUSE) begin
                pauseCnt <= pauseCnt - 1'b1;
            end else if (timeout) begin
                pauseCnt <= '0;
            end
`endif
            // modifiers track every decoded event, including ones the FIFO drops
            if (emit) begin
                if (emitCode == 8'h12 && !emitExt) oMod[0] <= !emitBrk;
                if (emitCode == 8'h59 && !emitExt) oMod[1] <= !emitBrk;
                if (emitCode == 8'h14)             oMod[2] <= !emitBrk;
                if (emitCode == 8'h11)             oMod[3] <= !emitBrk;
            end
        end
    end

    assign full       = (count == FULL_CNT);
    assign oEvt_Valid = (count != '0);
    assign pop        = oEvt_Valid && iEvt_Ready;
    assign push       = emit && (!full || pop);
    assign drop       = emit && full && !pop;

    assign {oEvt_Ext, oEvt_Break, oEvt_Code} = mem[rdPtr];

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // when full, the write lands in the slot being popped this cycle
            if (push) begin
                mem[wrPtr] <= {emitExt, emitBrk, emitCode};
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: vector table plus FIFO, timeout and reset sequences.
module tb_ps2_scan_ctrl;

    logic       CLOCK = 1'b0;
    logic       RST_n = 1'b0;
    logic       iTrig = 1'b0;
    logic [7:0] iData = '0;
    logic       iEvt_Ready = 1'b0;
    logic       oEvt_Valid;
    logic [7:0] oEvt_Code;
    logic       oEvt_Ext;
    logic       oEvt_Break;
    logic [3:0] oMod;
    logic       oDrop;
    logic [2:0] oState;

    ps2_scan_ctrl #(.TIMEOUT_CYC(100), .FIFO_DEPTH(4)) dut (
        .CLOCK      (CLOCK),
        .RST_n      (RST_n),
        .iTrig      (iTrig),
        .iData      (iData),
        .oEvt_Valid (oEvt_Valid),
        .iEvt_Ready (iEvt_Ready),
        .oEvt_Code  (oEvt_Code),
        .oEvt_Ext   (oEvt_Ext),
        .oEvt_Break (oEvt_Break),
        .oMod       (oMod),
        .oDrop      (oDrop),
        .oState     (oState)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];
    logic [9:0] expE;

    typedef struct {
        logic [7:0] data;
        logic       evt;
        logic [9:0] entry;
        logic [3:0] mod;
        logic [2:0] st;
        int         gap;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic e, input logic [9:0] ent);
        iTrig = 1'b1;
        iData = d;
        if (e) sb.push_back(ent);
        cyc();
        iTrig = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        @(negedge CLOCK);
        chk({nm, "_left"}, sb.size(), 0);
        chk({nm, "_valid"}, oEvt_Valid, 0);
    endtask

    function automatic void addV(input logic [7:0] d, input logic e, input logic x, input logic b,
                                 input logic [3:0] m, input logic [2:0] s, input int g);
        vec_t v;
        v.data  = d;
        v.evt   = e;
        v.entry = {x, b, d};
        v.mod   = m;
        v.st    = s;
        v.gap   = g;
        vecs.push_back(v);
    endfunction

    // scoreboard side: compare each accepted head against the oldest expected event
    always @(negedge CLOCK) begin
        if (RST_n && oEvt_Valid && iEvt_Ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected: got %0h expected none", {oEvt_Ext, oEvt_Break, oEvt_Code});
            end else begin
                expE = sb.pop_front();
                chk("evt", {22'd0, oEvt_Ext, oEvt_Break, oEvt_Code}, {22'd0, expE});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] codes[6];
        int bad;
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

        addV(8'h1C, 1, 0, 0, 4'b0000, 0, 100);
        addV(8'hF0, 0, 0, 0, 4'b0000, 2, 2);
        addV(8'h1C, 1, 0, 1, 4'b0000, 0, 2);
        addV(8'hE0, 0, 0, 0, 4'b0000, 1, 2);
        addV(8'h11, 1, 1, 0, 4'b1000, 0, 2);
        addV(8'hE0, 0, 0, 0, 4'b1000, 1, 2);
        addV(8'hF0, 0, 0, 0, 4'b1000, 3, 2);
        addV(8'h11, 1, 1, 1, 4'b0000, 0, 2);
        addV(8'h12, 1, 0, 0, 4'b0001, 0, 2);
        addV(8'h59, 1, 0, 0, 4'b0011, 0, 2);
        addV(8'hE0, 0, 0, 0, 4'b0011, 1, 2);
        addV(8'h12, 1, 1, 0, 4'b0011, 0, 2);
        addV(8'hF0, 0, 0, 0, 4'b0011, 2, 2);
        addV(8'h12, 1, 0, 1, 4'b0010, 0, 2);
        addV(8'hFA, 0, 0, 0, 4'b0010, 0, 2);
        addV(8'hAA, 0, 0, 0, 4'b0010, 0, 2);
        addV(8'h00, 0, 0, 0, 4'b0010, 0, 2);
        addV(8'hF0, 0, 0, 0, 4'b0010, 2, 2);
        addV(8'hE0, 0, 0, 0, 4'b0010, 0, 2);
        addV(8'hE0, 0, 0, 0, 4'b0010, 1, 2);
        addV(8'hE0, 0, 0, 0, 4'b0010, 1, 2);
        addV(8'h75, 1, 1, 0, 4'b0010, 0, 2);
        addV(8'hE0, 0, 0, 0, 4'b0010, 1, 2);
        addV(8'hF0, 0, 0, 0, 4'b0010, 3, 2);
        addV(8'hF0, 0, 0, 0, 4'b0010, 0, 2);
        addV(8'h14, 1, 0, 0, 4'b0110, 0, 2);
        addV(8'hF0, 0, 0, 0, 4'b0110, 2, 2);
        addV(8'h14, 1, 0, 1, 4'b0010, 0, 2);
        addV(8'hF0, 0, 0, 0, 4'b0010, 2, 2);
        addV(8'h59, 1, 0, 1, 4'b0000, 0, 2);
`ifdef PS2_PAUSE_EN
        addV(8'hE1, 0, 0, 0, 4'b0000, 4, 2);
        addV(8'h14, 0, 0, 0, 4'b0000, 4, 2);
        addV(8'h77, 0, 0, 0, 4'b0000, 4, 2);
        addV(8'hE1, 0, 0, 0, 4'b0000, 4, 2);
        addV(8'hF0, 0, 0, 0, 4'b0000, 4, 2);
        addV(8'h14, 0, 0, 0, 4'b0000, 4, 2);
        addV(8'hF0, 0, 0, 0, 4'b0000, 4, 2);
        vecs.push_back('{data: 8'h77, evt: 1'b1, entry: 10'h2E1, mod: 4'b0000, st: 3'd0, gap: 2});
`else
        addV(8'hE1, 0, 0, 0, 4'b0000, 0, 2);
        addV(8'h14, 1, 0, 0, 4'b0100, 0, 2);
        addV(8'h77, 1, 0, 0, 4'b0100, 0, 2);
        addV(8'hE1, 0, 0, 0, 4'b0100, 0, 2);
        addV(8'hF0, 0, 0, 0, 4'b0100, 2, 2);
        addV(8'h14, 1, 0, 1, 4'b0000, 0, 2);
        addV(8'hF0, 0, 0, 0, 4'b0000, 2, 2);
        addV(8'h77, 1, 0, 1, 4'b0000, 0, 2);
`endif

        // reset state, with a byte offered during reset
        iTrig = 1'b1;
        iData = 8'h1C;
        repeat (3) cyc();
        @(negedge CLOCK);
        chk("rst_valid", oEvt_Valid, 0);
        chk("rst_code", oEvt_Code, 0);
        chk("rst_ext", oEvt_Ext, 0);
        chk("rst_brk", oEvt_Break, 0);
        chk("rst_mod", oMod, 0);
        chk("rst_drop", oDrop, 0);
        chk("rst_state", oState, 0);
        cyc();
        RST_n = 1'b1;
        iTrig = 1'b0;
        iEvt_Ready = 1'b1;
        @(negedge CLOCK);
        chk("trig_in_reset", oEvt_Valid, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc();
            iTrig = 1'b1;
            iData = vecs[i].data;
            if (vecs[i].evt) sb.push_back(vecs[i].entry);
            @(negedge CLOCK);
            chk($sformatf("v%0d_prevalid", i), oEvt_Valid, 0);
            cyc();
            iTrig = 1'b0;
            @(negedge CLOCK);
            chk($sformatf("v%0d_mod", i), oMod, vecs[i].mod);
            chk($sformatf("v%0d_state", i), oState, vecs[i].st);
            if (vecs[i].evt) chk($sformatf("v%0d_valid", i), oEvt_Valid, 1);
            repeat (vecs[i].gap) cyc();
        end
        drain("table");

        // FIFO overflow with the consumer stalled
        iEvt_Ready = 1'b0;
        cyc();
        for (int k = 0; k < 6; k++) begin
            iTrig = 1'b1;
            iData = codes[k];
            if (k < 4) sb.push_back({2'b00, codes[k]});
            @(negedge CLOCK);
            chk($sformatf("ovf_drop%0d", k), oDrop, (k == 5) ? 1 : 0);
            cyc();
        end
        iTrig = 1'b0;
        @(negedge CLOCK);
        chk("ovf_drop6", oDrop, 1);
        chk("ovf_valid", oEvt_Valid, 1);
        chk("ovf_head", oEvt_Code, 8'h15);
        cyc();
        @(negedge CLOCK);
        chk("ovf_drop7", oDrop, 0);
        cyc();
        // push and pop together while full
        iTrig = 1'b1;
        iData = 8'h3C;
        iEvt_Ready = 1'b1;
        sb.push_back(10'h03C);
        cyc();
        iTrig = 1'b0;
        iEvt_Ready = 1'b0;
        @(negedge CLOCK);
        chk("pushpop_drop", oDrop, 0);
        chk("pushpop_valid", oEvt_Valid, 1);
        chk("pushpop_head", oEvt_Code, 8'h1D);
        cyc();
        iEvt_Ready = 1'b1;
        drain("fifo");

        // inter-byte timeout after a lone E0
        cyc();
        sendByte(8'hE0, 0, '0);
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLOCK);
            if (k <= 98 && oState !== 3'd1) bad++;
            if (k == 100) chk("to_idle", oState, 0);
            cyc();
        end
        chk("to_hold", bad, 0);
        repeat (48) cyc();
        sendByte(8'h1C, 1, 10'h01C);
        @(negedge CLOCK);
        chk("to_after_state", oState, 0);
        chk("to_after_valid", oEvt_Valid, 1);
        drain("timeout");

        // reset in the middle of a break sequence
        cyc();
        sendByte(8'h12, 1, 10'h012);
        @(negedge CLOCK);
        chk("mid_mod_set", oMod, 4'b0001);
        cyc();
        sendByte(8'hF0, 0, '0);
        RST_n = 1'b0;
        cyc();
        RST_n = 1'b1;
        @(negedge CLOCK);
        chk("mid_state", oState, 0);
        chk("mid_mod", oMod, 0);
        cyc();
        sendByte(8'h1C, 1, 10'h01C);
        @(negedge CLOCK);
        chk("mid_after_state", oState, 0);
        drain("midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
